// File: rtl/commit_trace_buffer.sv
// Retire-trace capture: classifies and numbers retired instructions into a FWFT circular FIFO,
// with retire/cycle counters and a cycle-limit watchdog. Optional macro: TRACE_LOAD_ADDR_EN.
module commit_trace_buffer #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned REG_AW    = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned CYC_LIMIT = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ret_valid,
    input  logic [DATA_W-1:0] ret_pc,
    input  logic              ret_regwrite,
    input  logic [REG_AW-1:0] ret_wreg,
    input  logic [DATA_W-1:0] ret_wdata,
    input  logic              ret_memread,
    input  logic              ret_memwrite,
    input  logic [DATA_W-1:0] ret_addr,
    input  logic [DATA_W-1:0] ret_mdata,
    input  logic              ret_halt,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [1:0]        rd_kind,
    output logic [DATA_W-1:0] rd_pc,
    output logic [REG_AW-1:0] rd_reg,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] rd_addr,
    output logic [CNT_W-1:0]  rd_inum,
    output logic [CNT_W-1:0]  inst_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              halted,
    output logic              timeout,
    output logic              overflow,
    output logic              full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [1:0] KIND_OTHER = 2'd0;
    localparam logic [1:0] KIND_REG   = 2'd1;
    localparam logic [1:0] KIND_STORE = 2'd2;
    localparam logic [1:0] KIND_HALT  = 2'd3;
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(CYC_LIMIT - 1);

    typedef enum logic [1:0] {RUN, HALTED, TIMEOUT} state_t;

    typedef struct packed {
        logic [1:0]        kind;
        logic [DATA_W-1:0] pc;
        logic [REG_AW-1:0] reg_idx;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] addr;
        logic [CNT_W-1:0]  inum;
    } rec_t;

    state_t            state_q, state_d;
    rec_t              mem [DEPTH];
    rec_t              rec_in, head;
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  cyc_inc, inst_inc;
    logic              push_req, push, pop, drop;

    assign cyc_inc  = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
    assign inst_inc = (inst_count  == '1) ? inst_count  : inst_count  + CNT_W'(1);

    // FIFO status: the extra pointer bit tells a full ring from an empty one
    assign rd_valid = (wr_ptr != rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop      = rd_valid && rd_ready;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Next state; halt outranks the watchdog on the same cycle
    always_comb begin
        state_d  = state_q;
        push_req = 1'b0;
        case (state_q)
            RUN: begin
                push_req = ret_valid;
                if (ret_valid && ret_halt)  state_d = HALTED;
                else if (cyc_inc == CYC_LAST) state_d = TIMEOUT;
            end
            HALTED:  state_d = HALTED;
            TIMEOUT: state_d = TIMEOUT;
            default: state_d = RUN;
        endcase
    end

    // Record classification: halt > regwrite > store > other
    always_comb begin
        rec_in      = '0;
        rec_in.pc   = ret_pc;
        rec_in.inum = inst_count;
        if (ret_halt) begin
            rec_in.kind = KIND_HALT;
        end else if (ret_regwrite) begin
            rec_in.kind    = KIND_REG;
            rec_in.reg_idx = ret_wreg;
            rec_in.data    = ret_wdata;
`ifdef TRACE_LOAD_ADDR_EN
            if (ret_memread) rec_in.addr = ret_addr;
`endif
        end else if (ret_memwrite) begin
            rec_in.kind = KIND_STORE;
            rec_in.data = ret_mdata;
            rec_in.addr = ret_addr;
        end else begin
            rec_in.kind = KIND_OTHER;
        end
    end

`ifndef TRACE_LOAD_ADDR_EN
    logic unused_memread;
    assign unused_memread = ret_memread;
`endif

    // Storage is not reset; validity comes from the pointers
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= rec_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    // Counters and terminal-state flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_count  <= '0;
            cycle_count <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            if (state_q == RUN) cycle_count <= cyc_inc;
            if (push_req)       inst_count  <= inst_inc;
            halted  <= (state_d == HALTED);
            timeout <= (state_d == TIMEOUT);
        end
    end

    // First-word-fall-through head, zeroed while empty
    assign head    = rd_valid ? mem[rd_ptr[PTR_W-1:0]] : '0;
    assign rd_kind = head.kind;
    assign rd_pc   = head.pc;
    assign rd_reg  = head.reg_idx;
    assign rd_data = head.data;
    assign rd_addr = head.addr;
    assign rd_inum = head.inum;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: expected records queued at stimulus time,
// a negedge monitor pops and compares every accepted head entry.
module tb_commit_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, rst_n_wd = 1'b0;
    logic        ret_valid = 1'b0, ret_regwrite = 1'b0, ret_memread = 1'b0;
    logic        ret_memwrite = 1'b0, ret_halt = 1'b0;
    logic [15:0] ret_pc = '0, ret_wdata = '0, ret_addr = '0, ret_mdata = '0;
    logic [3:0]  ret_wreg = '0;
    logic        rd_ready = 1'b0, rd_ready_wd = 1'b0;

    logic        rd_valid, halted, timeout, overflow, full;
    logic [1:0]  rd_kind;
    logic [15:0] rd_pc, rd_data, rd_addr;
    logic [3:0]  rd_reg;
    logic [31:0] rd_inum, inst_count, cycle_count;

    logic        w_rd_valid, w_halted, w_timeout, w_overflow, w_full;
    logic [1:0]  w_rd_kind;
    logic [15:0] w_rd_pc, w_rd_data, w_rd_addr;
    logic [3:0]  w_rd_reg;
    logic [31:0] w_rd_inum, w_inst_count, w_cycle_count;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] pc;
        logic [3:0]  rg;
        logic [15:0] data;
        logic [15:0] addr;
        logic [31:0] inum;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    commit_trace_buffer dut (
        .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .ret_regwrite(ret_regwrite), .ret_wreg(ret_wreg), .ret_wdata(ret_wdata),
        .ret_memread(ret_memread), .ret_memwrite(ret_memwrite), .ret_addr(ret_addr),
        .ret_mdata(ret_mdata), .ret_halt(ret_halt), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_kind(rd_kind), .rd_pc(rd_pc), .rd_reg(rd_reg),
        .rd_data(rd_data), .rd_addr(rd_addr), .rd_inum(rd_inum),
        .inst_count(inst_count), .cycle_count(cycle_count), .halted(halted),
        .timeout(timeout), .overflow(overflow), .full(full)
    );

    commit_trace_buffer #(.CYC_LIMIT(20)) dut_wd (
        .clk(clk), .rst_n(rst_n_wd), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .ret_regwrite(ret_regwrite), .ret_wreg(ret_wreg), .ret_wdata(ret_wdata),
        .ret_memread(ret_memread), .ret_memwrite(ret_memwrite), .ret_addr(ret_addr),
        .ret_mdata(ret_mdata), .ret_halt(ret_halt), .rd_ready(rd_ready_wd),
        .rd_valid(w_rd_valid), .rd_kind(w_rd_kind), .rd_pc(w_rd_pc), .rd_reg(w_rd_reg),
        .rd_data(w_rd_data), .rd_addr(w_rd_addr), .rd_inum(w_rd_inum),
        .inst_count(w_inst_count), .cycle_count(w_cycle_count), .halted(w_halted),
        .timeout(w_timeout), .overflow(w_overflow), .full(w_full)
    );

    // Monitor: every accepted head entry must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_record: got kind=%0d pc=%h inum=%0d, required none",
                         rd_kind, rd_pc, rd_inum);
            end else begin
                exp_t e, a;
                e = exp_q.pop_front();
                a = '{rd_kind, rd_pc, rd_reg, rd_data, rd_addr, rd_inum};
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL record_inum%0d: got kind=%0d pc=%h reg=%0d data=%h addr=%h inum=%0d, required kind=%0d pc=%h reg=%0d data=%h addr=%h inum=%0d",
                             e.inum, a.kind, a.pc, a.rg, a.data, a.addr, a.inum,
                             e.kind, e.pc, e.rg, e.data, e.addr, e.inum);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic expect_rec(input logic [1:0] kind, input logic [15:0] pc, input logic [3:0] rg,
                              input logic [15:0] data, input logic [15:0] addr, input logic [31:0] inum);
        exp_q.push_back('{kind, pc, rg, data, addr, inum});
    endtask

    // One retire pulse, sampled at the next rising edge
    task automatic retire(input logic [15:0] pc, input logic rw, input logic [3:0] wreg,
                          input logic [15:0] wdata, input logic mr, input logic mw,
                          input logic [15:0] addr, input logic [15:0] mdata, input logic hlt,
                          input logic vld = 1'b1);
        ret_valid = vld; ret_pc = pc; ret_regwrite = rw; ret_wreg = wreg; ret_wdata = wdata;
        ret_memread = mr; ret_memwrite = mw; ret_addr = addr; ret_mdata = mdata; ret_halt = hlt;
        @(posedge clk); #1;
        ret_valid = 1'b0; ret_halt = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ret_valid = 1'b0; rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        check({nm, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check({nm, "_empty"}, {31'd0, rd_valid}, 32'd0);
    endtask

    logic [15:0] load_addr_exp;

    initial begin
`ifdef TRACE_LOAD_ADDR_EN
        load_addr_exp = 16'h0200;
`else
        load_addr_exp = 16'h0000;
`endif
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rd_valid", {31'd0, rd_valid}, 0);
        check("rst_flags", {27'd0, full, overflow, halted, timeout, rd_valid}, 0);
        check("rst_inst_count", inst_count, 0);
        check("rst_cycle_count", cycle_count, 0);

        // Classification and numbering, drained as produced
        do_reset();
        rd_ready = 1'b1;
        expect_rec(1, 16'h0000, 1, 16'h0011, 0, 0); retire(16'h0000, 1, 1, 16'h0011, 0, 0, 0, 0, 0);
        expect_rec(1, 16'h0002, 2, 16'h0022, 0, 1); retire(16'h0002, 1, 2, 16'h0022, 0, 0, 0, 0, 0);
        expect_rec(1, 16'h0004, 3, 16'h0033, 0, 2); retire(16'h0004, 1, 3, 16'h0033, 0, 0, 0, 0, 0);
        expect_rec(2, 16'h0006, 0, 16'hBEEF, 16'h0100, 3);
        retire(16'h0006, 0, 5, 16'h1111, 0, 1, 16'h0100, 16'hBEEF, 0);
        expect_rec(1, 16'h0008, 4, 16'h1234, load_addr_exp, 4);
        retire(16'h0008, 1, 4, 16'h1234, 1, 0, 16'h0200, 0, 0);
        expect_rec(0, 16'h000A, 0, 0, 0, 5);
        retire(16'h000A, 0, 9, 16'h5555, 0, 0, 16'h7777, 16'h3333, 0);
        expect_rec(1, 16'h000C, 6, 16'h0066, 0, 6);
        retire(16'h000C, 1, 6, 16'h0066, 0, 1, 16'h0300, 16'h9999, 0);
        retire(16'h000E, 1, 7, 16'h0077, 0, 0, 0, 0, 1, 1'b0);
        wait_drain("p1");
        check("p1_inst_count", inst_count, 7);
        check("p1_not_halted", {31'd0, halted}, 0);

        // Overflow: 18 retires with the consumer stalled
        do_reset();
        for (int i = 0; i < 18; i++) begin
            if (i < 16) expect_rec(1, 16'(2 * i), 4'(i), 16'h0100 + 16'(i), 0, 32'(i));
            retire(16'(2 * i), 1, 4'(i), 16'h0100 + 16'(i), 0, 0, 0, 0, 0);
            if (i == 0) begin
                @(negedge clk);
                check("p2_latency_valid", {31'd0, rd_valid}, 1);
            end
            if (i == 15) begin
                @(negedge clk);
                check("p2_full_at16", {30'd0, full, overflow}, 32'b10);
            end
        end
        @(negedge clk);
        check("p2_full_after18", {31'd0, full}, 1);
        check("p2_overflow", {31'd0, overflow}, 1);
        check("p2_inst_count", inst_count, 18);
        @(posedge clk); #1;
        rd_ready = 1'b1;
        wait_drain("p2");
        check("p2_overflow_sticky", {30'd0, full, overflow}, 32'b01);

        // Simultaneous push and pop while full
        do_reset();
        for (int i = 0; i < 16; i++) begin
            expect_rec(1, 16'h0040 + 16'(2 * i), 4'(i), 16'h0200 + 16'(i), 0, 32'(i));
            retire(16'h0040 + 16'(2 * i), 1, 4'(i), 16'h0200 + 16'(i), 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        check("p3_full_before", {31'd0, full}, 1);
        @(posedge clk); #1;
        rd_ready = 1'b1;
        expect_rec(1, 16'h0060, 7, 16'h0777, 0, 16);
        retire(16'h0060, 1, 7, 16'h0777, 0, 0, 0, 0, 0);
        rd_ready = 1'b0;
        @(negedge clk);
        check("p3_full_after", {30'd0, full, overflow}, 32'b10);
        check("p3_inst_count", inst_count, 17);
        @(posedge clk); #1;
        rd_ready = 1'b1;
        wait_drain("p3");

        // Halt: priority over regwrite, then freeze
        do_reset();
        rd_ready = 1'b1;
        expect_rec(1, 16'h000C, 1, 16'hAAAA, 0, 0); retire(16'h000C, 1, 1, 16'hAAAA, 0, 0, 0, 0, 0);
        expect_rec(0, 16'h000E, 0, 0, 0, 1);        retire(16'h000E, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_rec(3, 16'h0010, 0, 0, 0, 2);        retire(16'h0010, 1, 2, 16'hFFFF, 0, 0, 0, 0, 1);
        @(negedge clk);
        check("p4_halted", {30'd0, halted, timeout}, 32'b10);
        check("p4_inst_count", inst_count, 3);
        check("p4_cycle_count", cycle_count, 3);
        retire(16'h0012, 1, 3, 16'h0123, 0, 0, 0, 0, 0);
        retire(16'h0014, 0, 0, 0, 0, 1, 16'h0400, 16'h0456, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("p4_cycle_frozen", cycle_count, 3);
        check("p4_inst_frozen", inst_count, 3);
        check("p4_no_push", {31'd0, rd_valid}, 0);
        check("p4_queue_left", 32'(exp_q.size()), 0);

        // Watchdog instance, limit 20, then asynchronous reset mid-run
        @(posedge clk); #1;
        rst_n_wd = 1'b1;
        retire(16'h0020, 1, 1, 16'h0001, 0, 0, 0, 0, 0);
        retire(16'h0022, 1, 2, 16'h0002, 0, 0, 0, 0, 0);
        repeat (16) @(posedge clk);
        @(negedge clk);
        check("wd_cycle18", w_cycle_count, 18);
        check("wd_no_timeout_18", {31'd0, w_timeout}, 0);
        @(negedge clk);
        check("wd_cycle19", w_cycle_count, 19);
        check("wd_timeout_19", {31'd0, w_timeout}, 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("wd_cycle_hold", w_cycle_count, 19);
        check("wd_timeout_hold", {30'd0, w_timeout, w_halted}, 32'b10);
        check("wd_inst_count", w_inst_count, 2);
        check("wd_entries", {31'd0, w_rd_valid}, 1);
        @(posedge clk); #3;
        rst_n_wd = 1'b0;
        #1;
        check("wd_arst_flags", {27'd0, w_rd_valid, w_full, w_overflow, w_halted, w_timeout}, 0);
        check("wd_arst_cycle", w_cycle_count, 0);
        check("wd_arst_inst", w_inst_count, 0);
        check("wd_arst_rd_pc", {16'd0, w_rd_pc}, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesizable retire-trace capture block for the 16-bit CPU.
- Generalised, in-design successor to the simulation-only trace logging: classifies each retired instruction (reg write, store, halt, other), numbers it, and buffers it in a parametrised circular FIFO that is drained through a valid/ready port.
- Also keeps instruction and cycle counters and a cycle-limit watchdog.
- Sits beside the CPU top level, fed from the writeback/commit stage; usable with single-cycle and pipelined cores.

Parameters:
- DATA_W, 16, width of PC, data and address fields.
- REG_AW, 4, register index width.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CNT_W, 32, width of the counters and the instruction number.
- CYC_LIMIT, 100000, watchdog cycle limit.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ret_valid  in  1  an instruction retires this cycle.
- ret_pc  in  DATA_W  PC of the retiring instruction.
- ret_regwrite  in  1  the instruction writes a register.
- ret_wreg  in  REG_AW  destination register.
- ret_wdata  in  DATA_W  register write data.
- ret_memread  in  1  the instruction is a load.
- ret_memwrite  in  1  the instruction is a store.
- ret_addr  in  DATA_W  memory address.
- ret_mdata  in  DATA_W  store data.
- ret_halt  in  1  the retiring instruction is HLT.
- rd_ready  in  1  consumer accepts the head entry.
- rd_valid  out  1  head entry is available.
- rd_kind  out  2  0=other (branch/NOP), 1=reg write, 2=store, 3=halt.
- rd_pc  out  DATA_W  head PC.
- rd_reg  out  REG_AW  head destination register (0 when not a reg write).
- rd_data  out  DATA_W  wdata for a reg write, mdata for a store, else 0.
- rd_addr  out  DATA_W  address for a store, else 0 (see Optional Feature).
- rd_inum  out  CNT_W  instruction number.
- inst_count  out  CNT_W  instructions retired.
- cycle_count  out  CNT_W  cycles since reset release.
- halted  out  1  halt has been recorded.
- timeout  out  1  watchdog expired.
- overflow  out  1  sticky: at least one record was dropped.
- full  out  1  FIFO holds DEPTH entries.

Behaviour:
- Reset: all outputs 0, FIFO empty, pointers 0, state RUN. Reset asserted mid-operation discards all contents immediately.
- FSM states:
  - RUN: ret_halt with ret_valid goes to HALTED; cycle_count reaching CYC_LIMIT-1 goes to TIMEOUT.
  - HALTED and TIMEOUT: terminal until reset. No pushes, no counting. Drain continues.
- If halt retires on the same cycle the limit is hit, halt wins.
- Classification, priority order: halt, then regwrite, then memwrite, then other. ret_* inputs are ignored when ret_valid=0.
- Push: a record is written on ret_valid in RUN. rd_inum is the inst_count value before the increment. inst_count increments on every accepted retire, including dropped ones.
- Drain: pop on rd_valid&rd_ready. rd_* outputs are driven combinationally from the head entry (first-word-fall-through). Output values are undefined when rd_valid=0.
- Full: a push while full without a same-cycle pop is dropped and overflow is set (sticky). A push and pop on the same cycle while full both succeed and full stays 1.
- Empty: rd_ready is ignored.
- Pointers are log2(DEPTH) bits wide, wrap modulo DEPTH, and carry an extra wrap bit for full/empty detection.
- Counters:
  - cycle_count increments every clk in RUN after reset release.
  - Both counters saturate at all-ones.
  - timeout=1 exactly when the state is TIMEOUT; halted=1 exactly when the state is HALTED.
- Latency: a record pushed at edge N is visible on rd_valid after edge N.

Optional Feature:
- Macro TRACE_LOAD_ADDR_EN.
- Defined: reg-write records with ret_memread=1 carry ret_addr in rd_addr, so load traces include the address.
- Undefined: rd_addr=0 for every kind except store.

Test Plan:
- Reset, then retire 3 reg writes (pc 0x0000/0x0002/0x0004, R1..R3, data 0x0011/0x0022/0x0033) with rd_ready=1: three kind=1 records with inum 0,1,2; inst_count=3.
- Store at pc 0x0006, addr 0x0100, mdata 0xBEEF: kind=2, rd_addr=0x0100, rd_data=0xBEEF, rd_reg=0.
- rd_ready=0, retire 18 instructions with DEPTH=16: full=1 after 16, overflow=1, inst_count=18. Draining yields inum 0..15 in order.
- Push and pop on the same cycle while full: count stays 16, full stays 1, no overflow.
- Retire HLT at pc 0x0010: kind=3, halted=1. Later retires are ignored and cycle_count freezes.
- CYC_LIMIT=20, no halt: timeout=1 at cycle_count=19 and stays set. Assert rst_n low mid-run: all outputs return to 0 asynchronously.
